fetch_fifo: RTL
===============

FETCH_FIFO -- requirements
Module: fetch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of entries; power of two, >= 2.
REQ-002 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port flush_i, input, 1, discard all entries (misprediction/exception redirect).
REQ-005 SHALL have port in_valid_i, input, 1, fetch presents an instruction.
REQ-006 SHALL have port in_ready_o, output, 1, FIFO accepts the instruction this cycle.
REQ-007 SHALL have port in_addr_i, input, 64, PC of the fetched instruction.
REQ-008 SHALL have port in_rdata_i, input, 32, raw instruction word.
REQ-009 SHALL have port in_bp_i, input, btb struct (129 bits: pc, branch_target_address, valid), branch prediction for this PC.
REQ-010 SHALL have port in_fault_i, input, 1, fetch access fault on this PC.
REQ-011 SHALL have port out_valid_o, output, 1, head entry valid for decode.
REQ-012 SHALL have port out_ready_i, input, 1, decode consumes the head entry.
REQ-013 SHALL have port out_pc_o, output, 64, head PC.
REQ-014 SHALL have port out_instr_o, output, 32, head instruction word.
REQ-015 SHALL have port out_bp_o, output, btb struct, head branch prediction.
REQ-016 SHALL have port out_ex_o, output, exception struct (epc 64, cause 64, valid 1), head exception.
REQ-017 SHALL have port count_o, output, clog2(DEPTH)+1, current occupancy.

Function
REQ-018 SHALL store entries in a circular buffer indexed by read/write pointers of clog2(DEPTH) bits, wrapping DEPTH-1 -> 0, plus an occupancy counter 0..DEPTH.
REQ-019 SHALL drive in_ready_o = (count != DEPTH) && !flush_i, purely from state and flush_i, never from out_ready_i.
REQ-020 SHALL push when in_valid_i && in_ready_o: write entry at write pointer, increment write pointer.
REQ-021 SHALL drive out_valid_o = (count != 0); no bypass, so minimum in-to-out latency is 1 cycle.
REQ-022 SHALL pop when out_valid_o && out_ready_i && !flush_i: increment read pointer.
REQ-023 SHALL, on simultaneous push and pop, keep count unchanged; when count == DEPTH, no push occurs (in_ready_o = 0) even if a pop occurs.
REQ-024 SHALL ignore out_ready_i when empty, and leave all state unchanged when in_valid_i is 0 and no pop.
REQ-025 SHALL hold out_* stable while out_valid_o && !out_ready_i && !flush_i.
REQ-026 SHALL, on flush_i, set count, read pointer and write pointer to 0 at the next edge; push and pop in that cycle are suppressed; out_valid_o = 0 the following cycle.
REQ-027 SHALL compute exception at push: in_fault_i=1 -> cause 1 (access fault); else in_addr_i[1:0] != 0 -> cause 0 (misaligned); else valid=0, cause 0; epc = in_addr_i whenever valid; access fault takes priority.
REQ-028 SHALL drive out_pc_o/out_instr_o/out_bp_o/out_ex_o from the entry at the read pointer; values when out_valid_o = 0 are don't-care but SHALL NOT be X after reset.
REQ-029 SHALL drive count_o equal to the occupancy counter.

Reset
REQ-030 SHALL, while rst_i = 1, immediately force pointers and count to 0, out_valid_o = 0, in_ready_o = 1 (when flush_i = 0), and storage to all zeros.
REQ-031 SHALL discard any in-flight push/pop on reset assertion mid-operation; first push after rst_i falls is accepted on the first clock edge.

Verification
REQ-032 Fill: reset, push PCs 0x80,0x84,0x88,0x8C with out_ready_i=0 -> count_o 4, in_ready_o 0; fifth push stalls; pops return 0x80..0x8C in order.
REQ-033 Streaming: in_valid_i and out_ready_i held 1, PCs 0x100+4k for 20 cycles -> count_o settles at 1, one output per cycle, pointers wrap without loss.
REQ-034 Full+pop: count 4, in_valid_i=1, out_ready_i=1 -> pop happens, push rejected, count_o 3 next cycle.
REQ-035 Flush: count 3, flush_i=1 with in_valid_i=1 -> in_ready_o 0 that cycle, next cycle count_o 0, out_valid_o 0; next push 0x200 emerges first.
REQ-036 Exceptions: push addr 0x102 -> out_ex_o valid=1, cause 0, epc 0x102; push 0x104 with in_fault_i=1 -> cause 1; push 0x106 with in_fault_i=1 -> cause 1.
REQ-037 Async reset: assert rst_i between edges with count 2 -> out_valid_o 0 and count_o 0 without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_fifo.sv
// Fetch-to-decode instruction queue: circular buffer, 1-cycle minimum latency (no bypass).
// in_ready_o drops only when full or flushing; head entry holds while decode stalls.
package fetch_fifo_pkg;
   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] branch_target_address;
      logic        valid;
   } btb_t;

   typedef struct packed {
      logic [63:0] epc;
      logic [63:0] cause;
      logic        valid;
   } exception_t;
endpackage

module fetch_fifo
   import fetch_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [63:0]                in_addr_i,
   input  logic [31:0]                in_rdata_i,
   input  btb_t                       in_bp_i,
   input  logic                       in_fault_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [63:0]                out_pc_o,
   output logic [31:0]                out_instr_o,
   output btb_t                       out_bp_o,
   output exception_t                 out_ex_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      btb_t        bp;
      exception_t  ex;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop;
   entry_t          new_entry;
   entry_t          head;

   assign in_ready_o  = (count_q != CW'(DEPTH)) && !flush_i;
   assign out_valid_o = (count_q != '0);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i && !flush_i;

   // Access fault outranks misalignment; epc is only meaningful when valid.
   always_comb begin
      new_entry       = '0;
      new_entry.pc    = in_addr_i;
      new_entry.instr = in_rdata_i;
      new_entry.bp    = in_bp_i;
      if (in_fault_i) begin
         new_entry.ex.valid = 1'b1;
         new_entry.ex.cause = 64'd1;
         new_entry.ex.epc   = in_addr_i;
      end else if (in_addr_i[1:0] != 2'b00) begin
         new_entry.ex.valid = 1'b1;
         new_entry.ex.cause = 64'd0;
         new_entry.ex.epc   = in_addr_i;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= new_entry;
      end
   end

   assign head        = mem_q[rd_ptr_q];
   assign out_pc_o    = head.pc;
   assign out_instr_o = head.instr;
   assign out_bp_o    = head.bp;
   assign out_ex_o    = head.ex;
   assign count_o     = count_q;
endmodule
